// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU core: sequencer state encoding and
// memory latency defaults also used by the memory wrappers.
package cpu_pkg;

  localparam int unsigned IMEM_LAT_DEFAULT = 1;
  localparam int unsigned DMEM_LAT_DEFAULT = 1;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StEcall  = 3'd6
  } state_e;

  function automatic int unsigned max_lat(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Single-cycle rising-edge pulse from a level input, using one history flop.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= din;
    end
  end

  assign rise = din & ~prev_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: steps fetch/decode/execute/memory/write-back,
// issues all architectural write strobes, stalls ecall on the confirm button.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned IMEM_LAT = IMEM_LAT_DEFAULT,
  parameter int unsigned DMEM_LAT = DMEM_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run_en,
  input  logic        step,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        reg_write,
  input  logic        ecall,
  input  logic        io_confirm,
  output logic        ir_we,
  output logic        pc_we,
  output logic        rf_we,
  output logic        dmem_re,
  output logic        dmem_we,
  output logic        io_wb,
  output logic        ecall_wait,
  output logic [2:0]  state,
  output logic [31:0] instret
);

  localparam int unsigned CntW = $clog2(max_lat(IMEM_LAT, DMEM_LAT) + 1);
  localparam logic [CntW-1:0] FetchLast = CntW'(IMEM_LAT - 1);
  localparam logic [CntW-1:0] MemLast   = CntW'(DMEM_LAT - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q;
  logic [31:0]     instret_q;
  logic            is_ecall_q;
  logic            step_rise, confirm_rise;

  rise_detect u_step_rise (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (step),
    .rise (step_rise)
  );

  rise_detect u_confirm_rise (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (io_confirm),
    .rise (confirm_rise)
  );

  always_comb begin
    state_d    = state_q;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    rf_we      = 1'b0;
    dmem_re    = 1'b0;
    dmem_we    = 1'b0;
    io_wb      = 1'b0;
    ecall_wait = 1'b0;
    case (state_q)
      StIdle: begin
        if (run_en || step_rise) state_d = StFetch;
      end
      StFetch: begin
        ir_we = (cnt_q == FetchLast);
        if (cnt_q == FetchLast) state_d = StDecode;
      end
      StDecode: state_d = StExec;
      StExec: begin
        if (ecall) begin
          state_d = StEcall;
        end else if (mem_read || mem_write) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        dmem_re = mem_read;
        // Single write strobe per store regardless of access latency.
        dmem_we = mem_write && (cnt_q == '0);
        if (cnt_q == MemLast) state_d = StWb;
      end
      StEcall: begin
        ecall_wait = 1'b1;
        if (confirm_rise) state_d = StWb;
      end
      StWb: begin
        pc_we   = 1'b1;
        rf_we   = reg_write | is_ecall_q;
        io_wb   = is_ecall_q;
        state_d = run_en ? StFetch : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      instret_q  <= '0;
      is_ecall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (state_q == StFetch || state_q == StMem) begin
        cnt_q <= cnt_q + 1'b1;
      end
      // Remember ecall so the write-back strobes stay pure state decodes.
      if (state_q == StExec) is_ecall_q <= ecall;
      if (state_q == StWb) instret_q <= instret_q + 32'd1;
    end
  end

  assign state   = state_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized scoreboard bench for cpu_sequencer: per-instruction expectations are
// queued at issue and compared by a monitor when the instruction retires (pc_we).
module tb_cpu_sequencer;

  localparam int unsigned IMEM = 1;
  localparam int unsigned DMEM = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        run_en = 1'b0;
  logic        step = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic        reg_write = 1'b0;
  logic        ecall = 1'b0;
  logic        io_confirm = 1'b0;
  logic        ir_we, pc_we, rf_we, dmem_re, dmem_we, io_wb, ecall_wait;
  logic [2:0]  state;
  logic [31:0] instret;

  always #5 clk = ~clk;

  cpu_sequencer #(
    .IMEM_LAT(IMEM),
    .DMEM_LAT(DMEM)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run_en    (run_en),
    .step      (step),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .reg_write (reg_write),
    .ecall     (ecall),
    .io_confirm(io_confirm),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .rf_we     (rf_we),
    .dmem_re   (dmem_re),
    .dmem_we   (dmem_we),
    .io_wb     (io_wb),
    .ecall_wait(ecall_wait),
    .state     (state),
    .instret   (instret)
  );

  typedef struct {
    int lat;
    int wait_cyc;
    int rf;
    int io;
    int re_cnt;
    int we_cnt;
    int we_pos;
    int idx;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   issued = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Instruction-level model: cycle cost and strobe counts from the flag rules.
  function automatic exp_t model(input bit mr, input bit mw, input bit rw, input bit ec,
                                 input int w);
    exp_t e;
    bit   is_mem;
    is_mem     = !ec && (mr || mw);
    e.wait_cyc = ec ? w : 0;
    e.lat      = IMEM + 3 + (ec ? w : (is_mem ? DMEM : 0));
    e.rf       = (rw || ec) ? 1 : 0;
    e.io       = ec ? 1 : 0;
    e.re_cnt   = (is_mem && mr) ? DMEM : 0;
    e.we_cnt   = (is_mem && mw) ? 1 : 0;
    e.we_pos   = (is_mem && mw) ? IMEM + 2 : -1;
    e.idx      = 0;
    return e;
  endfunction

  task automatic issue(input bit mr, input bit mw, input bit rw, input bit ec,
                       input int h, input int r);
    exp_t e;
    mem_read  = mr;
    mem_write = mw;
    reg_write = rw;
    ecall     = ec;
    e         = model(mr, mw, rw, ec, h + r + 1);
    e.idx     = issued;
    issued++;
    exp_q.push_back(e);
    if (ec) io_confirm = (h > 0);
  endtask

  // Drives the confirm button for an ecall, then waits for retirement.
  task automatic finish_instr(input bit ec, input int h, input int r);
    bit seen;
    if (ec) begin
      seen = 1'b0;
      for (int k = 0; k < 100 && !seen; k++) begin
        @(negedge clk);
        if (ecall_wait) seen = 1'b1;
      end
      if (!seen) begin
        check("ecall_wait_timeout", 0, 1);
      end else begin
        repeat (h) @(posedge clk);
        #1 io_confirm = 1'b0;
        repeat (r) @(posedge clk);
        #1 io_confirm = 1'b1;
      end
    end
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (pc_we) seen = 1'b1;
    end
    if (!seen) check("retire_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (ec) io_confirm = 1'b0;
  endtask

  task automatic step_pulse();
    @(posedge clk);
    #1 step = 1'b1;
    @(posedge clk);
    #1 step = 1'b0;
  endtask

  task automatic rand_instr(input bit last);
    bit mr, mw, rw, ec;
    int h, r;
    int unsigned k;
    mr = 0; mw = 0; rw = 0; ec = 0; h = 0; r = 1;
    k  = $urandom_range(0, 9);
    case (k)
      0, 1: begin
        ec = 1;
        mr = 1'($urandom_range(0, 1));
        rw = 1'($urandom_range(0, 1));
        h  = int'($urandom_range(0, 2));
        r  = int'($urandom_range(1, 3));
      end
      2, 3: begin mr = 1; rw = 1; end
      4, 5: mw = 1;
      6: begin mr = 1; mw = 1; rw = 1'($urandom_range(0, 1)); end
      default: rw = 1'($urandom_range(0, 1));
    endcase
    issue(mr, mw, rw, ec, h, r);
    if (last) begin
      @(posedge clk);
      #1 run_en = 1'b0;
    end
    finish_instr(ec, h, r);
  endtask

  // Monitor: accumulates strobes from FETCH entry and scores at retirement.
  bit   m_active = 1'b0;
  int   m_cyc, m_ir_cnt, m_ir_pos, m_re, m_we, m_we_pos, m_wait, m_rf, m_io;
  exp_t m_exp;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_active = 1'b0;
    end else begin
      if (!m_active && pc_we) check("stray_pc_we", pc_we, 0);
      if (!m_active && state == 3'd1) begin
        m_active = 1'b1;
        m_cyc = 0; m_ir_cnt = 0; m_ir_pos = -1; m_re = 0; m_we = 0;
        m_we_pos = -1; m_wait = 0; m_rf = 0; m_io = 0;
      end
      if (m_active) begin
        if (ir_we) begin m_ir_cnt++; m_ir_pos = m_cyc; end
        if (dmem_re) m_re++;
        if (dmem_we) begin
          m_we++;
          if (m_we_pos < 0) m_we_pos = m_cyc;
        end
        if (ecall_wait) m_wait++;
        if (rf_we) m_rf++;
        if (io_wb) m_io++;
        if (pc_we) begin
          if (exp_q.size() == 0) begin
            check("retire_unexpected", pc_we, 0);
          end else begin
            m_exp = exp_q.pop_front();
            check("latency", m_cyc + 1, m_exp.lat);
            check("ir_we_count", m_ir_cnt, 1);
            check("ir_we_cycle", m_ir_pos, IMEM - 1);
            check("dmem_re_count", m_re, m_exp.re_cnt);
            check("dmem_we_count", m_we, m_exp.we_cnt);
            check("dmem_we_cycle", m_we_pos, m_exp.we_pos);
            check("ecall_wait_cycles", m_wait, m_exp.wait_cyc);
            check("rf_we", m_rf, m_exp.rf);
            check("io_wb", m_io, m_exp.io);
            check("instret_at_wb", longint'(instret), m_exp.idx);
          end
          m_active = 1'b0;
        end
        m_cyc++;
      end
    end
  end

  initial begin
    bit seen;
    #1 rst_n = 1'b0;
    #2;
    check("rst_state", state, 0);
    check("rst_instret", instret, 0);
    check("rst_strobes", {ir_we, pc_we, rf_we, dmem_re, dmem_we, io_wb, ecall_wait}, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    repeat (3) @(posedge clk);
    #1 check("idle_hold", state, 0);

    // Directed: ALU, store, load, ecall with button held on entry.
    issue(0, 0, 1, 0, 0, 1);
    run_en = 1'b1;
    finish_instr(0, 0, 1);
    issue(0, 1, 0, 0, 0, 1);
    finish_instr(0, 0, 1);
    issue(1, 0, 1, 0, 0, 1);
    finish_instr(0, 0, 1);
    issue(0, 0, 0, 1, 3, 2);
    finish_instr(1, 3, 2);

    for (int i = 0; i < 60; i++) rand_instr(i == 59);
    repeat (3) @(posedge clk);
    #1;
    check("idle_after_run_drop", state, 0);
    check("instret_run", longint'(instret), issued);

    // Reset during the first MEM cycle of a store.
    run_en = 1'b1;
    issue(0, 1, 0, 0, 0, 1);
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      if (dmem_we) seen = 1'b1;
    end
    if (!seen) check("store_timeout", 0, 1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_state", state, 0);
    check("abort_dmem_we", dmem_we, 0);
    check("abort_pc_we", pc_we, 0);
    check("abort_instret", instret, 0);
    exp_q.delete();
    issued = 0;
    issue(0, 0, 1, 0, 0, 1);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 check("fetch_after_reset", state, 1);
    run_en = 1'b0;
    finish_instr(0, 0, 1);

    // Single-step: three step edges, the second during an instruction.
    @(negedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    issued = 0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    issue(1, 0, 1, 0, 0, 1);
    step_pulse();
    step_pulse();
    finish_instr(0, 0, 1);
    repeat (4) @(posedge clk);
    #1;
    check("step_idle_state", state, 0);
    check("step_instret_1", longint'(instret), issued);
    issue(0, 0, 1, 0, 0, 1);
    step_pulse();
    finish_instr(0, 0, 1);
    repeat (4) @(posedge clk);
    #1;
    check("step_final_state", state, 0);
    check("step_instret_2", longint'(instret), 2);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0t required=<2000000", $time);
    $fatal(1, "timeout");
  end

endmodule
